// File: rtl/sel_dispatch_fifo.sv
// Buffered dispatcher: tagged 32-bit words in, one word + lane select out for the 1-to-4 selector.
// Latency: 1 cycle from push edge to Out_valid (no bypass); 1 push + 1 pop per cycle sustained.
// Backpressure: In_ready depends only on registered occupancy; a pop while full frees space next cycle.
//
// Ports:
//   Clk, Rst_n               - clock (rising edge), asynchronous active-low reset
//   In_valid/In_ready        - upstream handshake; In_data payload, In_dest lane 0..3
//   Out_valid/Out_ready      - downstream handshake; Out_data/Out_sel drive selector In/Sel
//   Flush                    - synchronous discard of all buffered words (hold register kept)
//   Count                    - occupancy 0..DEPTH
//   Lane_cnt0..Lane_cnt3     - per-lane dispatch counters
//
// Optional feature macro: SEL_DISPATCH_STATS_EN enables the per-lane counters;
// without it the counters are absent and Lane_cntN read as zero.

module sel_dispatch_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     In_valid,
    output logic                     In_ready,
    input  logic [31:0]              In_data,
    input  logic [1:0]               In_dest,
    output logic                     Out_valid,
    input  logic                     Out_ready,
    output logic [31:0]              Out_data,
    output logic [1:0]               Out_sel,
    input  logic                     Flush,
    output logic [$clog2(DEPTH):0]   Count,
    output logic [CNT_W-1:0]         Lane_cnt0,
    output logic [CNT_W-1:0]         Lane_cnt1,
    output logic [CNT_W-1:0]         Lane_cnt2,
    output logic [CNT_W-1:0]         Lane_cnt3
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    // Entry layout: {dest[1:0], data[31:0]}
    logic [33:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q,  count_d;
    logic [33:0]      hold_q,   hold_d;
    logic [33:0]      head;
    logic             push;
    logic             pop;

    assign head      = mem_q[rd_ptr_q];
    assign In_ready  = (count_q != OCC_W'(DEPTH));
    assign Out_valid = (count_q != '0);
    assign Count     = count_q;

    // Flush wins over both handshakes, so it gates them here once.
    assign push = In_valid  && In_ready  && !Flush;
    assign pop  = Out_valid && Out_ready && !Flush;

    // While empty, present the last dispatched word so the level-sensitive
    // selector downstream sees no input change.
    assign Out_data = Out_valid ? head[31:0]  : hold_q[31:0];
    assign Out_sel  = Out_valid ? head[33:32] : hold_q[33:32];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                hold_d   = head;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + OCC_W'(1);
                2'b01:   count_d = count_q - OCC_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    // Storage is data-only; its contents are meaningless until Count covers them.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {In_dest, In_data};
        end
    end

`ifdef SEL_DISPATCH_STATS_EN
    logic [CNT_W-1:0] lane_cnt_q [4];
    logic [CNT_W-1:0] lane_cnt_d [4];

    // Counters survive Flush; only reset clears them. Wrap is natural overflow.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_cnt_d[i] = lane_cnt_q[i];
        end
        if (pop) begin
            lane_cnt_d[head[33:32]] = lane_cnt_q[head[33:32]] + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < 4; i++) begin
                lane_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                lane_cnt_q[i] <= lane_cnt_d[i];
            end
        end
    end

    assign Lane_cnt0 = lane_cnt_q[0];
    assign Lane_cnt1 = lane_cnt_q[1];
    assign Lane_cnt2 = lane_cnt_q[2];
    assign Lane_cnt3 = lane_cnt_q[3];
`else
    assign Lane_cnt0 = '0;
    assign Lane_cnt1 = '0;
    assign Lane_cnt2 = '0;
    assign Lane_cnt3 = '0;
`endif

endmodule
